mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and committed when the busy window closes.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MduCtrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OP_W  = 4;
   localparam int unsigned CNT_W = 5;

   localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
   localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
   localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [OP_W-1:0]  op_q,    op_d;
   logic [XLEN-1:0]  a_q,     a_d;
   logic [XLEN-1:0]  b_q,     b_d;
   logic [XLEN-1:0]  hi_q,    hi_d;
   logic [XLEN-1:0]  lo_q,    lo_d;

   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]   quot_c, rem_c;
   logic [XLEN-1:0]   a_mag, b_mag, q_mag, r_mag;
   logic [2*XLEN-1:0] a_ext, b_ext;
   logic              a_neg, b_neg;

   // Datapath: the low 64 bits of a product of extended operands equal the signed/unsigned product
   always_comb begin
      a_ext  = (op_q == OP_MULT) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
      b_ext  = (op_q == OP_MULT) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
      prod_c = a_ext * b_ext;

      // Signed divide on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000
      a_neg  = (op_q == OP_DIV) && a_q[XLEN-1];
      b_neg  = (op_q == OP_DIV) && b_q[XLEN-1];
      a_mag  = a_neg ? (~a_q + XLEN'(1)) : a_q;
      b_mag  = b_neg ? (~b_q + XLEN'(1)) : b_q;
      q_mag  = '0;
      r_mag  = '0;
      if (b_mag != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quot_c = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
      rem_c  = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
   end

   // Next-state: accept when idle, count down while busy, commit on the last busy edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (MduCtrl)
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  OP_MULT, OP_MULTU: begin
                     state_d = S_BUSY;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = MduCtrl;
                     a_d     = A;
                     b_d     = B;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = S_BUSY;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = MduCtrl;
                     a_d     = A;
                     b_d     = B;
                  end
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                  hi_d = prod_c[2*XLEN-1:XLEN];
                  lo_d = prod_c[XLEN-1:0];
               end else if (b_q != '0) begin
                  hi_d = rem_c;
                  lo_d = quot_c;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == S_BUSY);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
